// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
// Lines are moved to and from memory one 32-bit word at a time.
package mem_arb_pkg;

    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = LINE_WORDS * 32;
    localparam int CNT_W      = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IC_XFER,
        S_DC_XFER,
        S_RESP
    } state_e;

    typedef enum logic {
        GNT_IC,
        GNT_DC
    } gnt_e;

    // Byte address of word cnt inside the line whose upper bits are line_tag.
    function automatic logic [31:0] word_addr(input logic [27:0]      line_tag,
                                              input logic [CNT_W-1:0] cnt);
        return {line_tag, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, main memory and the arbiter.
// The arbiter takes the slave view; the caches and memory take the master view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              ic_req_i;
    logic [31:0]       ic_addr_i;
    logic [LINE_W-1:0] ic_line_o;
    logic              ic_done_o;

    logic              dc_req_i;
    logic              dc_we_i;
    logic [31:0]       dc_addr_i;
    logic [LINE_W-1:0] dc_wline_i;
    logic [LINE_W-1:0] dc_line_o;
    logic              dc_done_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    logic              mem_ack_i;

    logic              busy_o;

    modport slave (
        input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wline_i,
               mem_rdata_i, mem_ack_i,
        output ic_line_o, ic_done_o, dc_line_o, dc_done_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );

    modport master (
        output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wline_i,
               mem_rdata_i, mem_ack_i,
        input  ic_line_o, ic_done_o, dc_line_o, dc_done_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );

endinterface

// File: rtl/mem_arb_linebuf.sv
// Word counter plus line (de)serialiser: gathers fill words into an assembly
// buffer, commits the finished line to the owning cache, and slices writeback words.
module mem_arb_linebuf
    import mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              ack_i,
    input  logic              fill_i,
    input  logic              dst_dc_i,
    input  logic [LINE_W-1:0] wline_i,
    input  logic [31:0]       rdata_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              last_o,
    output logic [31:0]       wdata_o,
    output logic [LINE_W-1:0] ic_line_o,
    output logic [LINE_W-1:0] dc_line_o
);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][31:0]  asm_q, asm_d;
    logic [LINE_W-1:0]            ic_line_q, ic_line_d;
    logic [LINE_W-1:0]            dc_line_q, dc_line_d;
    logic [LINE_WORDS-1:0][31:0]  wline_w;

    assign wline_w = wline_i;
    assign last_o  = (cnt_q == CNT_W'(LINE_WORDS - 1));

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        ic_line_d = ic_line_q;
        dc_line_d = dc_line_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (ack_i) begin
            cnt_d = cnt_q + 1'b1;
            if (fill_i) begin
                asm_d[cnt_q] = rdata_i;
                // The cache-visible line only changes once the whole fill has landed.
                if (last_o) begin
                    if (dst_dc_i) dc_line_d = asm_d;
                    else          ic_line_d = asm_d;
                end
            end
        end
    end

    // NOTE: the line storage is reset along with the counter because the line outputs must read zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            ic_line_q <= '0;
            dc_line_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            ic_line_q <= ic_line_d;
            dc_line_q <= dc_line_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign wdata_o   = wline_w[cnt_q];
    assign ic_line_o = ic_line_q;
    assign dc_line_o = dc_line_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter moving whole cache lines between an I-cache, a D-cache
// and a word-wide main memory, one line transfer at a time.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);

    state_e            state_q;
    gnt_e              last_grant_q;
    logic [27:0]       line_tag_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              ic_done_q;
    logic              dc_done_q;

    logic              gnt_valid;
    gnt_e              gnt_sel;
    logic              in_xfer;
    logic [CNT_W-1:0]  cnt;
    logic              last_word;
    logic [31:0]       wdata_word;
    logic              unused_addr_bits;

    // Line addresses are aligned; the low nibble carries no information.
    assign unused_addr_bits = ^{bus.ic_addr_i[3:0], bus.dc_addr_i[3:0]};

    always_comb begin
        gnt_valid = bus.ic_req_i | bus.dc_req_i;
        gnt_sel   = GNT_IC;
        if (bus.ic_req_i && bus.dc_req_i)
            gnt_sel = (last_grant_q == GNT_IC) ? GNT_DC : GNT_IC;
        else if (bus.dc_req_i)
            gnt_sel = GNT_DC;
    end

    assign in_xfer = (state_q == S_IC_XFER) || (state_q == S_DC_XFER);

    mem_arb_linebuf u_linebuf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   ((state_q == S_IDLE) && gnt_valid),
        .ack_i     (in_xfer && bus.mem_ack_i),
        .fill_i    (!mem_we_q),
        .dst_dc_i  (state_q == S_DC_XFER),
        .wline_i   (bus.dc_wline_i),
        .rdata_i   (bus.mem_rdata_i),
        .cnt_o     (cnt),
        .last_o    (last_word),
        .wdata_o   (wdata_word),
        .ic_line_o (bus.ic_line_o),
        .dc_line_o (bus.dc_line_o)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_IC;
            line_tag_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        state_q      <= (gnt_sel == GNT_DC) ? S_DC_XFER : S_IC_XFER;
                        last_grant_q <= gnt_sel;
                        line_tag_q   <= (gnt_sel == GNT_DC) ? bus.dc_addr_i[31:4]
                                                            : bus.ic_addr_i[31:4];
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= (gnt_sel == GNT_DC) && bus.dc_we_i;
                        busy_q       <= 1'b1;
                    end
                end
                S_IC_XFER, S_DC_XFER: begin
                    if (bus.mem_ack_i && last_word) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        ic_done_q <= (state_q == S_IC_XFER);
                        dc_done_q <= (state_q == S_DC_XFER);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = in_xfer ? word_addr(line_tag_q, cnt) : 32'h0;
    assign bus.mem_wdata_o = in_xfer ? wdata_word : 32'h0;
    assign bus.busy_o      = busy_q;
    assign bus.ic_done_o   = ic_done_q;
    assign bus.dc_done_o   = dc_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory returns address + 0x1000_0000 as read data.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata_i = bus.mem_addr_o + 32'h1000_0000;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] fill_line(input logic [31:0] base);
        logic [LINE_WORDS-1:0][31:0] w;
        for (int k = 0; k < LINE_WORDS; k++) w[k] = 32'h1000_0000 + base + 32'(4 * k);
        return w;
    endfunction

    task automatic test_reset();
        bus.ic_req_i = 0; bus.ic_addr_i = 0; bus.dc_req_i = 0; bus.dc_we_i = 0;
        bus.dc_addr_i = 0; bus.dc_wline_i = '0; bus.mem_ack_i = 0;
        rst = 1; cyc(); cyc(); rst = 0; cyc();
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o); else passes++;
        checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req_o); else passes++;
        checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we_o); else passes++;
        checks++; if (bus.mem_addr_o !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr_o); else passes++;
        checks++; if (bus.mem_wdata_o !== 32'h0) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata_o); else passes++;
        checks++; if (bus.ic_line_o !== '0) $display("FAIL reset_ic_line: got %h expected 0", bus.ic_line_o); else passes++;
        checks++; if (bus.dc_line_o !== '0) $display("FAIL reset_dc_line: got %h expected 0", bus.dc_line_o); else passes++;
        checks++; if ({bus.ic_done_o, bus.dc_done_o} !== 2'b00) $display("FAIL reset_done: got %b expected 00", {bus.ic_done_o, bus.dc_done_o}); else passes++;
    endtask

    task automatic test_ic_fill();
        bus.ic_req_i = 1; bus.ic_addr_i = 32'h0000_1004; bus.mem_ack_i = 1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            checks++; if (bus.busy_o !== 1'b1) $display("FAIL ic_busy c%0d: got %b expected 1", c, bus.busy_o); else passes++;
            checks++; if (bus.mem_req_o !== (c <= 4)) $display("FAIL ic_mem_req c%0d: got %b expected %b", c, bus.mem_req_o, (c <= 4)); else passes++;
            checks++; if (bus.ic_done_o !== (c == 5)) $display("FAIL ic_done c%0d: got %b expected %b", c, bus.ic_done_o, (c == 5)); else passes++;
            checks++; if (bus.dc_done_o !== 1'b0) $display("FAIL ic_dc_done c%0d: got %b expected 0", c, bus.dc_done_o); else passes++;
            if (c <= 4) begin
                checks++; if (bus.mem_addr_o !== 32'h1000 + 32'(4 * (c - 1))) $display("FAIL ic_addr c%0d: got %h expected %h", c, bus.mem_addr_o, 32'h1000 + 32'(4 * (c - 1))); else passes++;
                checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL ic_we c%0d: got %b expected 0", c, bus.mem_we_o); else passes++;
            end
        end
        checks++; if (bus.ic_line_o !== {32'h1000_100C, 32'h1000_1008, 32'h1000_1004, 32'h1000_1000}) $display("FAIL ic_line: got %h expected 1000100c100010081000100410001000", bus.ic_line_o); else passes++;
        cyc(); bus.ic_req_i = 0; bus.mem_ack_i = 0;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL ic_after_busy: got %b expected 0", bus.busy_o); else passes++;
        checks++; if (bus.ic_done_o !== 1'b0) $display("FAIL ic_after_done: got %b expected 0", bus.ic_done_o); else passes++;
    endtask

    // Two tie rounds: D-cache wins each, I-cache follows in the IDLE cycle after RESP.
    task automatic test_tie();
        logic [31:0] dc_base, ic_base, exp_addr;
        rst = 1; cyc(); rst = 0;
        bus.mem_ack_i = 1; bus.dc_we_i = 0;
        for (int r = 0; r < 2; r++) begin
            dc_base = (r == 0) ? 32'h3000 : 32'h3100;
            ic_base = (r == 0) ? 32'h2000 : 32'h2100;
            bus.ic_addr_i = ic_base; bus.dc_addr_i = dc_base;
            bus.ic_req_i = 1; bus.dc_req_i = 1;
            for (int c = 1; c <= 11; c++) begin
                cyc();
                if (c == 6) bus.dc_req_i = 0;
                exp_addr = (c <= 4) ? dc_base + 32'(4 * (c - 1)) :
                           (c >= 7 && c <= 10) ? ic_base + 32'(4 * (c - 7)) : 32'h0;
                checks++; if (bus.busy_o !== (c != 6)) $display("FAIL tie%0d_busy c%0d: got %b expected %b", r, c, bus.busy_o, (c != 6)); else passes++;
                checks++; if (bus.mem_addr_o !== exp_addr) $display("FAIL tie%0d_addr c%0d: got %h expected %h", r, c, bus.mem_addr_o, exp_addr); else passes++;
                checks++; if (bus.mem_req_o !== (c <= 4 || (c >= 7 && c <= 10))) $display("FAIL tie%0d_req c%0d: got %b", r, c, bus.mem_req_o); else passes++;
                checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL tie%0d_we c%0d: got %b expected 0", r, c, bus.mem_we_o); else passes++;
                checks++; if (bus.dc_done_o !== (c == 5)) $display("FAIL tie%0d_dc_done c%0d: got %b expected %b", r, c, bus.dc_done_o, (c == 5)); else passes++;
                checks++; if (bus.ic_done_o !== (c == 11)) $display("FAIL tie%0d_ic_done c%0d: got %b expected %b", r, c, bus.ic_done_o, (c == 11)); else passes++;
            end
            checks++; if (bus.dc_line_o !== fill_line(dc_base)) $display("FAIL tie%0d_dc_line: got %h expected %h", r, bus.dc_line_o, fill_line(dc_base)); else passes++;
            checks++; if (bus.ic_line_o !== fill_line(ic_base)) $display("FAIL tie%0d_ic_line: got %h expected %h", r, bus.ic_line_o, fill_line(ic_base)); else passes++;
            cyc(); bus.ic_req_i = 0;
        end
        bus.mem_ack_i = 0;
    endtask

    task automatic test_writeback();
        int k;
        bus.dc_req_i = 1; bus.dc_we_i = 1; bus.dc_addr_i = 32'h4000; bus.mem_ack_i = 0;
        bus.dc_wline_i = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
        for (int c = 1; c <= 13; c++) begin
            cyc();
            bus.mem_ack_i = (c % 3 == 0);
            k = (c - 1) / 3;
            if (c <= 12) begin
                checks++; if (bus.mem_req_o !== 1'b1) $display("FAIL wb_req c%0d: got %b expected 1", c, bus.mem_req_o); else passes++;
                checks++; if (bus.mem_we_o !== 1'b1) $display("FAIL wb_we c%0d: got %b expected 1", c, bus.mem_we_o); else passes++;
                checks++; if (bus.mem_addr_o !== 32'h4000 + 32'(4 * k)) $display("FAIL wb_addr c%0d: got %h expected %h", c, bus.mem_addr_o, 32'h4000 + 32'(4 * k)); else passes++;
                checks++; if (bus.mem_wdata_o !== 32'h1111 * 32'(k + 1)) $display("FAIL wb_wdata c%0d: got %h expected %h", c, bus.mem_wdata_o, 32'h1111 * 32'(k + 1)); else passes++;
                checks++; if (bus.dc_done_o !== 1'b0) $display("FAIL wb_early_done c%0d: got %b expected 0", c, bus.dc_done_o); else passes++;
            end
        end
        checks++; if (bus.dc_done_o !== 1'b1) $display("FAIL wb_done: got %b expected 1", bus.dc_done_o); else passes++;
        checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL wb_resp_req: got %b expected 0", bus.mem_req_o); else passes++;
        checks++; if (bus.dc_line_o !== fill_line(32'h3100)) $display("FAIL wb_dc_line: got %h expected %h", bus.dc_line_o, fill_line(32'h3100)); else passes++;
        cyc(); bus.dc_req_i = 0; bus.dc_we_i = 0;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL wb_after_busy: got %b expected 0", bus.busy_o); else passes++;
    endtask

    task automatic test_idle_ack();
        bus.mem_ack_i = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            checks++; if (bus.busy_o !== 1'b0) $display("FAIL idle_busy c%0d: got %b expected 0", c, bus.busy_o); else passes++;
            checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL idle_req c%0d: got %b expected 0", c, bus.mem_req_o); else passes++;
            checks++; if (bus.ic_line_o !== fill_line(32'h2100)) $display("FAIL idle_ic_line c%0d: got %h", c, bus.ic_line_o); else passes++;
            checks++; if (bus.dc_line_o !== fill_line(32'h3100)) $display("FAIL idle_dc_line c%0d: got %h", c, bus.dc_line_o); else passes++;
        end
        bus.mem_ack_i = 0;
    endtask

    task automatic test_reset_mid();
        bus.ic_req_i = 1; bus.ic_addr_i = 32'h5000; bus.mem_ack_i = 1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            checks++; if (bus.mem_addr_o !== 32'h5000 + 32'(4 * (c - 1))) $display("FAIL rm_addr c%0d: got %h expected %h", c, bus.mem_addr_o, 32'h5000 + 32'(4 * (c - 1))); else passes++;
        end
        rst = 1; bus.ic_req_i = 0;
        cyc();
        rst = 0; bus.mem_ack_i = 0;
        checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL rm_req: got %b expected 0", bus.mem_req_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL rm_busy: got %b expected 0", bus.busy_o); else passes++;
        checks++; if (bus.ic_line_o !== '0) $display("FAIL rm_ic_line: got %h expected 0", bus.ic_line_o); else passes++;
        for (int c = 0; c < 6; c++) begin
            checks++; if ({bus.ic_done_o, bus.dc_done_o} !== 2'b00) $display("FAIL rm_done c%0d: got %b expected 00", c, {bus.ic_done_o, bus.dc_done_o}); else passes++;
            checks++; if (bus.busy_o !== 1'b0) $display("FAIL rm_idle_busy c%0d: got %b expected 0", c, bus.busy_o); else passes++;
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_ic_fill();
        test_tie();
        test_writeback();
        test_idle_ack();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_WORDS, 4: 32-bit words per cache line, fixed at 4 in this revision.
REQ-002 Parameter LINE_W, 128: line width in bits, equal to LINE_WORDS*32.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 ic_req_i  in  1  I-cache line-fill request; held high until ic_done_o is sampled.
REQ-006 ic_addr_i  in  32  I-cache line address; bits [3:0] are ignored.
REQ-007 ic_line_o  out  LINE_W  fill line for the I-cache; word 0 is in bits [31:0].
REQ-008 ic_done_o  out  1  one-cycle pulse when the I-cache transfer completes.
REQ-009 dc_req_i  in  1  D-cache request (fill or writeback); held high until dc_done_o is sampled.
REQ-010 dc_we_i  in  1  1 = writeback, 0 = fill; sampled at grant.
REQ-011 dc_addr_i  in  32  D-cache line address; bits [3:0] are ignored.
REQ-012 dc_wline_i  in  LINE_W  writeback line data; held stable while dc_req_i is high.
REQ-013 dc_line_o  out  LINE_W  fill line for the D-cache.
REQ-014 dc_done_o  out  1  one-cycle pulse when the D-cache transfer completes.
REQ-015 mem_req_o  out  1  word request to main memory.
REQ-016 mem_we_o  out  1  word write enable to main memory.
REQ-017 mem_addr_o  out  32  byte address of the current word.
REQ-018 mem_wdata_o  out  32  write data for the current word.
REQ-019 mem_rdata_i  in  32  read data; valid when mem_ack_i is high.
REQ-020 mem_ack_i  in  1  word accepted or completed; at most one per cycle.
REQ-021 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have four states, IDLE, IC_XFER, DC_XFER and RESP, plus a 2-bit word counter cnt and a last_grant flag (IC or DC).
REQ-023 In IDLE with exactly one request high, the FSM SHALL move to that requester's XFER state on the next edge, latch its address, and for D-cache latch dc_we_i; cnt is cleared.
REQ-024 In IDLE with both requests high, the FSM SHALL grant the requester that is not last_grant (round-robin); last_grant updates at grant time.
REQ-025 In XFER, the block SHALL drive mem_req_o=1, mem_addr_o={line_addr[31:4], cnt, 2'b00}, mem_we_o=latched we (0 for I-cache), and mem_wdata_o=dc_wline_i[cnt*32 +: 32].
REQ-026 On mem_ack_i in XFER for a fill, the block SHALL store mem_rdata_i into line word cnt and increment cnt; for a writeback it SHALL only increment cnt, leaving line buffers unchanged.
REQ-027 On mem_ack_i with cnt==LINE_WORDS-1, the FSM SHALL move to RESP.
REQ-028 RESP SHALL last exactly one cycle: the granted requester's done pulses high and the FSM returns to IDLE; mem_req_o=0 in RESP and IDLE.
REQ-029 ic_line_o and dc_line_o SHALL hold their last completed value until the next fill for the same requester overwrites them.
REQ-030 Latency: with mem_ack_i tied high, done SHALL assert LINE_WORDS+1 cycles after the request is first sampled in IDLE (5 cycles).
REQ-031 A requester SHALL drop its req on the edge at which it samples done; a req still high in IDLE is treated as a new request.
REQ-032 Dropping a req mid-transfer is a protocol violation; the transfer still completes and done still pulses.
REQ-033 mem_ack_i outside XFER SHALL be ignored.
REQ-034 A request arriving during another requester's transfer SHALL wait; it is served from IDLE after RESP.

Reset
REQ-035 On rst_i: FSM=IDLE, cnt=0, last_grant=IC (so D-cache wins the first tie), both line outputs 0, both done outputs 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0.
REQ-036 Reset sampled mid-transfer SHALL abandon the transfer without a done pulse; mem_req_o is 0 from the next cycle.

Structure
REQ-037 Package mem_arb_pkg SHALL hold LINE_WORDS, LINE_W, the FSM state enum and the grant enum {GNT_IC, GNT_DC}.
REQ-038 One sub-module, mem_arb_linebuf, SHALL hold the line deserialise and serialise buffer and the word counter; the FSM and round-robin logic stay in mem_arbiter.

Verification
REQ-039 I-cache alone, ic_addr_i=0x0000_1004, ack tied high -> mem_addr_o sequence 0x1000/0x1004/0x1008/0x100C; ic_done_o at cycle 5; ic_line_o holds the four returned words.
REQ-040 Both requests raised in the same cycle after reset -> D-cache granted first, I-cache granted in the IDLE cycle after D-cache's RESP; next tie goes to D-cache again.
REQ-041 D-cache writeback with dc_wline_i=0x4444_3333_2222_1111 (words 3..0), ack every 3rd cycle -> mem_we_o=1; mem_wdata_o is 0x1111 then 0x2222, 0x3333, 0x4444 (low halves of the 32-bit words, upper halves zero); dc_line_o unchanged; dc_done_o after the 4th ack.
REQ-042 rst_i asserted after the 2nd ack of a fill -> no done pulse; mem_req_o=0 the next cycle; busy_o=0.
REQ-043 mem_ack_i=1 while in IDLE with no request -> no state change and line outputs unchanged.
